// File: rtl/gpr_dbg_ctrl.sv
// Debug register-file access: halts the core, performs one read/write on the debug port, returns a response.
// Latency 3 cycles from IDLE (2 from HOLD while halted); one request in flight, req_ready_o low until the response drains.
module gpr_dbg_ctrl #(
  parameter int TIMEOUT     = 64,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        halt_req_o,
  input  logic        halted_i,
  output logic        jtag_en_o,
  output logic [4:0]  jtag_addr_o,
  output logic [31:0] jtag_data_o,
  input  logic [31:0] jtag_rdata_i
);

  localparam int CNT_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    RESP,
    HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          live_q;
  logic          req_fire;
  logic          wr_commit;

  // live_q keeps req_ready_o low while reset is held and for the first edge after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign req_ready_o = live_q && ((state_q == IDLE) || (state_q == HOLD));
  assign req_fire    = req_valid_i && req_ready_o;
  assign wr_commit   = (state_q == ACCESS) && we_q && (addr_q != 5'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (req_fire) begin
      we_d    = req_we_i;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
    end

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          cnt_d   = '0;
          state_d = HALT_WAIT;
        end
      end
      HALT_WAIT: begin
        if (halted_i) begin
          state_d = ACCESS;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACCESS: begin
        rdata_d = (!we_q && (addr_q != 5'd0)) ? jtag_rdata_i : 32'd0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i) begin
          cnt_d   = '0;
          state_d = err_q ? IDLE : HOLD;
        end
      end
      HOLD: begin
        // A late request beats hold expiry.
        if (req_fire) begin
          cnt_d   = '0;
          state_d = halted_i ? ACCESS : HALT_WAIT;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign halt_req_o   = (state_q == HALT_WAIT) || (state_q == ACCESS) || (state_q == HOLD) ||
                        ((state_q == RESP) && !err_q);
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = (state_q == RESP) ? rdata_q : 32'd0;
  assign resp_err_o   = (state_q == RESP) && err_q;
  assign jtag_en_o    = wr_commit;
  assign jtag_addr_o  = (state_q == ACCESS) ? addr_q : 5'd0;
  assign jtag_data_o  = wr_commit ? wdata_q : 32'd0;

endmodule

// File: tb/tb_gpr_dbg_ctrl.sv
// Directed bench for gpr_dbg_ctrl with default TIMEOUT=64, HOLD_CYCLES=16.
module tb_gpr_dbg_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        halt_req_o;
  logic        halted_i;
  logic        jtag_en_o;
  logic [4:0]  jtag_addr_o;
  logic [31:0] jtag_data_o;
  logic [31:0] jtag_rdata_i;

  int checks = 0;
  int fails  = 0;
  int en_cnt = 0;
  int rv_cnt = 0;

  gpr_dbg_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .halt_req_o   (halt_req_o),
    .halted_i     (halted_i),
    .jtag_en_o    (jtag_en_o),
    .jtag_addr_o  (jtag_addr_o),
    .jtag_data_o  (jtag_data_o),
    .jtag_rdata_i (jtag_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (jtag_en_o) en_cnt++;
    if (resp_valid_o) rv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one request for a single cycle; returns one cycle after the handshake edge.
  task automatic send(input logic we, input logic [4:0] a, input logic [31:0] d);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    tick();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = 5'd0;
    req_wdata_i = 32'd0;
  endtask

  task automatic drain_and_release();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    repeat (16) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int en0;
    int rv0;
    int lows;
    int early;

    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = 5'd0;
    req_wdata_i  = 32'd0;
    resp_ready_i = 1'b0;
    halted_i     = 1'b0;
    jtag_rdata_i = 32'd0;

    repeat (3) tick();
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_halt", 32'(halt_req_o), 32'd0);
    chk("rst_jtag_en", 32'(jtag_en_o), 32'd0);
    chk("rst_jtag_addr", 32'(jtag_addr_o), 32'd0);
    chk("rst_jtag_data", jtag_data_o, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_err", 32'(resp_err_o), 32'd0);
    rst_i = 1'b0;
    tick();
    tick();
    chk("idle_ready", 32'(req_ready_o), 32'd1);

    // Write x5 from IDLE, halted_i already high.
    halted_i = 1'b1;
    en0 = en_cnt;
    send(1'b1, 5'd5, 32'hDEADBEEF);
    chk("t1_halt_t1", 32'(halt_req_o), 32'd1);
    chk("t1_ready_t1", 32'(req_ready_o), 32'd0);
    chk("t1_en_t1", 32'(jtag_en_o), 32'd0);
    tick();
    chk("t1_en_t2", 32'(jtag_en_o), 32'd1);
    chk("t1_addr_t2", 32'(jtag_addr_o), 32'd5);
    chk("t1_data_t2", jtag_data_o, 32'hDEADBEEF);
    tick();
    chk("t1_rv_t3", 32'(resp_valid_o), 32'd1);
    chk("t1_err_t3", 32'(resp_err_o), 32'd0);
    chk("t1_rdata_t3", resp_rdata_o, 32'd0);
    chk("t1_en_t3", 32'(jtag_en_o), 32'd0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("t1_hold_rv", 32'(resp_valid_o), 32'd0);
    chk("t1_hold_halt", 32'(halt_req_o), 32'd1);
    chk("t1_hold_ready", 32'(req_ready_o), 32'd1);
    repeat (16) tick();
    chk("t1_release_halt", 32'(halt_req_o), 32'd0);
    chk("t1_release_ready", 32'(req_ready_o), 32'd1);
    chk("t1_en_pulses", 32'(en_cnt - en0), 32'd1);

    // Read x7, halted_i rises 4 cycles after accept.
    halted_i     = 1'b0;
    jtag_rdata_i = 32'h12345678;
    en0 = en_cnt;
    send(1'b0, 5'd7, 32'd0);
    repeat (3) tick();
    chk("t2_wait_halt", 32'(halt_req_o), 32'd1);
    chk("t2_wait_rv", 32'(resp_valid_o), 32'd0);
    halted_i = 1'b1;
    tick();
    chk("t2_acc_addr", 32'(jtag_addr_o), 32'd7);
    chk("t2_acc_rv", 32'(resp_valid_o), 32'd0);
    tick();
    chk("t2_rv", 32'(resp_valid_o), 32'd1);
    chk("t2_rdata", resp_rdata_o, 32'h12345678);
    chk("t2_err", 32'(resp_err_o), 32'd0);
    chk("t2_no_en", 32'(en_cnt - en0), 32'd0);
    drain_and_release();
    chk("t2_release_halt", 32'(halt_req_o), 32'd0);

    // Three back-to-back writes batched under one halt.
    resp_ready_i = 1'b1;
    send(1'b1, 5'd1, 32'h00000111);
    tick();
    tick();
    chk("t3_rv_first", 32'(resp_valid_o), 32'd1);
    tick();
    chk("t3_hold_halt", 32'(halt_req_o), 32'd1);
    for (int k = 2; k <= 3; k++) begin
      send(1'b1, 5'(k), 32'h00000111 * 32'(k));
      chk("t3_acc_en", 32'(jtag_en_o), 32'd1);
      chk("t3_acc_addr", 32'(jtag_addr_o), 32'(k));
      chk("t3_acc_data", jtag_data_o, 32'h00000111 * 32'(k));
      chk("t3_acc_halt", 32'(halt_req_o), 32'd1);
      tick();
      chk("t3_rv_2cyc", 32'(resp_valid_o), 32'd1);
      chk("t3_rv_halt", 32'(halt_req_o), 32'd1);
      tick();
    end
    resp_ready_i = 1'b0;
    lows = 0;
    repeat (15) begin
      if (!halt_req_o) lows++;
      tick();
    end
    chk("t3_hold_lows", 32'(lows), 32'd0);
    chk("t3_last_hold_halt", 32'(halt_req_o), 32'd1);
    tick();
    chk("t3_release_halt", 32'(halt_req_o), 32'd0);
    chk("t3_release_ready", 32'(req_ready_o), 32'd1);

    // Halt timeout.
    halted_i = 1'b0;
    en0 = en_cnt;
    send(1'b0, 5'd9, 32'd0);
    early = 0;
    repeat (63) begin
      tick();
      if (resp_valid_o) early++;
    end
    chk("t4_early_rv", 32'(early), 32'd0);
    tick();
    chk("t4_rv", 32'(resp_valid_o), 32'd1);
    chk("t4_err", 32'(resp_err_o), 32'd1);
    chk("t4_halt_at_resp", 32'(halt_req_o), 32'd0);
    chk("t4_rdata", resp_rdata_o, 32'd0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("t4_after_rv", 32'(resp_valid_o), 32'd0);
    chk("t4_after_halt", 32'(halt_req_o), 32'd0);
    chk("t4_after_ready", 32'(req_ready_o), 32'd1);
    chk("t4_no_en", 32'(en_cnt - en0), 32'd0);

    // halted_i arriving on the timeout cycle wins.
    send(1'b0, 5'd10, 32'd0);
    repeat (63) tick();
    halted_i = 1'b1;
    tick();
    chk("t4b_acc_rv", 32'(resp_valid_o), 32'd0);
    chk("t4b_acc_addr", 32'(jtag_addr_o), 32'd10);
    tick();
    chk("t4b_rv", 32'(resp_valid_o), 32'd1);
    chk("t4b_err", 32'(resp_err_o), 32'd0);
    chk("t4b_rdata", resp_rdata_o, 32'h12345678);
    drain_and_release();

    // x0: write dropped, read returns zero; then accept in last HOLD cycle.
    jtag_rdata_i = 32'hAAAA5555;
    en0 = en_cnt;
    send(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    chk("t5_w_en", 32'(jtag_en_o), 32'd0);
    chk("t5_w_data", jtag_data_o, 32'd0);
    tick();
    chk("t5_w_rv", 32'(resp_valid_o), 32'd1);
    chk("t5_w_err", 32'(resp_err_o), 32'd0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    send(1'b0, 5'd0, 32'd0);
    chk("t5_r_en", 32'(jtag_en_o), 32'd0);
    tick();
    chk("t5_r_rv", 32'(resp_valid_o), 32'd1);
    chk("t5_r_rdata", resp_rdata_o, 32'd0);
    chk("t5_r_err", 32'(resp_err_o), 32'd0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("t5_no_en", 32'(en_cnt - en0), 32'd0);
    repeat (15) tick();
    chk("t5_last_hold_ready", 32'(req_ready_o), 32'd1);
    send(1'b1, 5'd4, 32'h00000044);
    chk("t5_late_en", 32'(jtag_en_o), 32'd1);
    chk("t5_late_addr", 32'(jtag_addr_o), 32'd4);
    tick();
    chk("t5_late_rv", 32'(resp_valid_o), 32'd1);
    drain_and_release();
    chk("t5_release_halt", 32'(halt_req_o), 32'd0);

    // Reset during HALT_WAIT.
    halted_i = 1'b0;
    en0 = en_cnt;
    send(1'b1, 5'd6, 32'h00000066);
    tick();
    chk("t6_pre_halt", 32'(halt_req_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("t6_rst_halt", 32'(halt_req_o), 32'd0);
    chk("t6_rst_rv", 32'(resp_valid_o), 32'd0);
    chk("t6_rst_ready", 32'(req_ready_o), 32'd0);
    chk("t6_rst_en", 32'(jtag_en_o), 32'd0);
    tick();
    tick();
    rst_i    = 1'b0;
    halted_i = 1'b1;
    tick();
    chk("t6_ready", 32'(req_ready_o), 32'd1);
    rv0 = rv_cnt;
    repeat (8) tick();
    chk("t6_no_resp", 32'(rv_cnt - rv0), 32'd0);
    chk("t6_no_write", 32'(en_cnt - en0), 32'd0);
    chk("t6_idle_halt", 32'(halt_req_o), 32'd0);

    // Reset during RESP.
    jtag_rdata_i = 32'h12345678;
    send(1'b0, 5'd8, 32'd0);
    tick();
    tick();
    chk("t6b_pre_rv", 32'(resp_valid_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("t6b_rst_rv", 32'(resp_valid_o), 32'd0);
    chk("t6b_rst_rdata", resp_rdata_o, 32'd0);
    chk("t6b_rst_halt", 32'(halt_req_o), 32'd0);
    chk("t6b_rst_err", 32'(resp_err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    rv0 = rv_cnt;
    repeat (5) tick();
    chk("t6b_no_resp", 32'(rv_cnt - rv0), 32'd0);
    chk("t6b_ready", 32'(req_ready_o), 32'd1);

    // Normal transaction after reset.
    jtag_rdata_i = 32'hCAFEF00D;
    send(1'b0, 5'd3, 32'd0);
    chk("t6c_halt", 32'(halt_req_o), 32'd1);
    tick();
    chk("t6c_acc_addr", 32'(jtag_addr_o), 32'd3);
    tick();
    chk("t6c_rv", 32'(resp_valid_o), 32'd1);
    chk("t6c_rdata", resp_rdata_o, 32'hCAFEF00D);
    chk("t6c_err", 32'(resp_err_o), 32'd0);
    drain_and_release();
    chk("t6c_release_halt", 32'(halt_req_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/gpr_dbg_ctrl.md
# gpr_dbg_ctrl

Debug-access controller for the general-purpose register file. It accepts single-register read/write requests from the JTAG debug module and halts the core pipeline so the register-file write port is free. It then performs the access through the register file's debug port and returns a response. A hold window keeps the core halted between back-to-back debug accesses so that debug batches do not repeatedly stall and release the pipeline.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles spent waiting for `halted_i` before the access is aborted; legal range ≥2.
- HOLD_CYCLES, 16: idle cycles the core stays halted after a response before release; legal range ≥1.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- req_valid_i  in  1  debug request valid.
- req_ready_o  out  1  controller can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  5  register index.
- req_wdata_i  in  32  write data.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumed.
- resp_rdata_o  out  32  read data; 0 for writes.
- resp_err_o  out  1  1 = aborted by halt timeout.
- halt_req_o  out  1  request pipeline halt.
- halted_i  in  1  pipeline is halted, with no writeback in flight.
- jtag_en_o  out  1  register-file debug write enable.
- jtag_addr_o  out  5  register-file debug address.
- jtag_data_o  out  32  register-file debug write data.
- jtag_rdata_i  in  32  register-file debug read data, combinational from `jtag_addr_o`.

## Operation
States:
- **IDLE**
  - `req_ready_o` = 1.
  - A request handshake (`req_valid_i && req_ready_o`) captures `we`, `addr` and `wdata` into local registers, clears the counter, and moves to HALT_WAIT.
- **HALT_WAIT**
  - `halt_req_o` = 1.
  - `halted_i` = 1 → ACCESS.
  - Otherwise the counter increments. When the counter equals TIMEOUT-1 and `halted_i` = 0 → RESP with err = 1.
- **ACCESS** (exactly one cycle)
  - `jtag_addr_o` = captured address.
  - Write with addr ≠ 0: `jtag_en_o` = 1 and `jtag_data_o` = captured data.
  - Write to addr 0: `jtag_en_o` stays 0; the write is silently dropped with err = 0.
  - Read: `jtag_rdata_i` is captured into the response register, forced to 0 when addr = 0.
  - Next state is RESP with err = 0.
- **RESP**
  - `resp_valid_o` = 1; rdata and err are held stable until `resp_ready_i`.
  - On handshake: err = 0 → HOLD with the counter cleared; err = 1 → IDLE.
  - `halt_req_o` = 1 only if err = 0.
- **HOLD**
  - `halt_req_o` = 1 and `req_ready_o` = 1.
  - On request handshake, the request is captured and the next state is:
    - ACCESS if `halted_i` = 1 in the handshake cycle;
    - HALT_WAIT (counter cleared) if `halted_i` = 0.
  - With no request, the counter increments; reaching HOLD_CYCLES-1 → IDLE.

Other rules:
- `req_ready_o` = 0 in HALT_WAIT, ACCESS and RESP.
- `jtag_en_o` is asserted only in ACCESS.
- All outputs decode from registered state or registered data; there is no combinational path from any input to any output.
- Counter width is clog2(max(TIMEOUT, HOLD_CYCLES)) + 1. The counter saturates and never wraps.
- Reset mid-operation:
  - All state returns to IDLE immediately and all outputs go to 0.
  - An in-flight request is lost and no response is issued.
  - A write whose ACCESS cycle has not completed never reaches the register file.
  - `halt_req_o` drops asynchronously.

## Timing
Reset values: `req_ready_o` = 0 while reset is asserted, then 1 (IDLE). `resp_valid_o`, `resp_rdata_o`, `resp_err_o`, `halt_req_o`, `jtag_en_o`, `jtag_addr_o` and `jtag_data_o` are all 0.

Latencies, with the request accepted at cycle T:
- From IDLE:
  - HALT_WAIT at T+1; `halt_req_o` is high from T+1.
  - If `halted_i` = 1 at T+1: ACCESS at T+2 and `resp_valid_o` at T+3 (3-cycle minimum).
  - Each extra cycle of `halted_i` = 0 adds one cycle.
- From HOLD with `halted_i` = 1: ACCESS at T+1 and `resp_valid_o` at T+2.
- Timeout: with `halted_i` never high, `resp_valid_o` with err = 1 at T+1+TIMEOUT.
- Release: after a response handshake at cycle R with no new request, IDLE and `halt_req_o` = 0 from R+1+HOLD_CYCLES.
- Simultaneous events:
  - A request arriving in the last HOLD cycle is accepted; the accept takes priority over expiry.
  - If `halted_i` rises in the same cycle the timeout is reached, `halted_i` wins and the access proceeds to ACCESS.

## Test plan
- **Write from IDLE:** reset; write x5 = 0xDEADBEEF, `halted_i` tied high. Expect `halt_req_o` at T+1; `jtag_en_o` = 1 with addr 5 and data 0xDEADBEEF at T+2; resp err = 0 and rdata = 0 at T+3.
- **Read with delayed halt:** read x7 with `jtag_rdata_i` = 0x12345678 and `halted_i` rising 4 cycles after accept. Expect ACCESS one cycle after `halted_i` rises, then resp rdata = 0x12345678, and `jtag_en_o` never asserted.
- **Hold batching:** 3 back-to-back writes with `resp_ready_i` = 1. Expect the second and third responses 2 cycles after accept, `halt_req_o` continuously high, and deassertion exactly HOLD_CYCLES+1 cycles after the last response.
- **Timeout:** `halted_i` = 0 and TIMEOUT = 64. Expect resp err = 1 at T+65, `jtag_en_o` never set, and `halt_req_o` = 0 at the response and after it.
- **x0 handling:** write x0 = 0xFFFFFFFF then read x0 with `jtag_rdata_i` = 0xAAAA5555. Expect no `jtag_en_o` pulse, both err = 0, and read rdata = 0.
- **Reset mid-operation:** assert `rst_i` during HALT_WAIT and again during RESP. Expect all outputs 0 in the same cycle, no response after release, and a normal next transaction.
